fetch_sequencer: RTL and testbench

- Instruction-fetch front end of the 9-bit processor. Owns the 10-bit PC and addresses InstROM.
- Decodes the control-flow class of the returned instruction and resolves branch targets through an 8-entry lookup table.
- Latches compare flags from the ALU and drives the halt flag seen by the testbench.
- Replaces ad-hoc PC logic with an explicit run/stall/halt state machine.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/branch_resolve.sv | 33 +++
 rtl/fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_fetch_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Branch-target table and control-flow decode constants live here.
package fetch_pkg;

  localparam int unsigned PC_W      = 10;
  localparam int unsigned INST_W    = 9;
  localparam int unsigned LUT_DEPTH = 8;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_e;

  localparam logic [2:0] CF_CLASS  = 3'b111;
  localparam logic [2:0] COND_HALT = 3'b000;
  localparam logic [2:0] COND_BEQ  = 3'b001;
  localparam logic [2:0] COND_BNE  = 3'b010;
  localparam logic [2:0] COND_BGT  = 3'b011;
  localparam logic [2:0] COND_BLE  = 3'b100;
  localparam logic [2:0] COND_JMP  = 3'b101;

  localparam logic [PC_W-1:0] BRANCH_LUT [LUT_DEPTH] = '{
    10'd16, 10'd24, 10'd32, 10'd40, 10'd48, 10'd100, 10'd200, 10'd1023
  };

endpackage

// File: rtl/branch_resolve.sv
// Combinational control-flow decode: classifies the instruction, evaluates
// the branch condition against the registered flags and looks up the target.
module branch_resolve
  import fetch_pkg::*;
(
  input  logic [INST_W-1:0] instruction_i,
  input  logic              f_eq_i,
  input  logic              f_gt_i,
  output logic              is_cf_o,
  output logic              is_halt_o,
  output logic              take_o,
  output logic [PC_W-1:0]   target_o
);

  always_comb begin
    is_cf_o   = (instruction_i[8:6] == CF_CLASS);
    is_halt_o = 1'b0;
    take_o    = 1'b0;
    target_o  = BRANCH_LUT[instruction_i[2:0]];
    if (is_cf_o) begin
      case (instruction_i[5:3])
        COND_HALT: is_halt_o = 1'b1;
        COND_BEQ:  take_o    = f_eq_i;
        COND_BNE:  take_o    = !f_eq_i;
        COND_BGT:  take_o    = f_gt_i;
        COND_BLE:  take_o    = !f_gt_i;
        COND_JMP:  take_o    = 1'b1;
        default:   take_o    = 1'b0;  // 110/111 are NOPs
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front end: PC register, BOOT/RUN/HALTED sequencing and compare flags.
// Define FETCH_PERF_EN to add saturating instr_count/taken_count outputs.
module fetch_sequencer
  import fetch_pkg::*;
(
  input  logic              CLK,
  input  logic              start,
  input  logic              stall,
  input  logic              flag_we,
  input  logic              EQUAL,
  input  logic              GT,
  input  logic [INST_W-1:0] Instruction,
  output logic [PC_W-1:0]   PC,
  output logic              inst_valid,
  output logic              branch_taken,
  output logic              halt,
  output logic              pc_overflow
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_W-1:0]  instr_count,
  output logic [CNT_W-1:0]  taken_count
`endif
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            f_eq_q, f_eq_d;
  logic            f_gt_q, f_gt_d;
  logic            pc_overflow_q, pc_overflow_d;

  logic            is_cf, is_halt, take;
  logic [PC_W-1:0] target;
  logic            active;

  branch_resolve u_branch_resolve (
    .instruction_i (Instruction),
    .f_eq_i        (f_eq_q),
    .f_gt_i        (f_gt_q),
    .is_cf_o       (is_cf),
    .is_halt_o     (is_halt),
    .take_o        (take),
    .target_o      (target)
  );

  assign active = (state_q == RUN) && !stall;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    f_eq_d        = f_eq_q;
    f_gt_d        = f_gt_q;
    pc_overflow_d = pc_overflow_q;
    inst_valid    = 1'b0;
    branch_taken  = 1'b0;

    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!stall) begin
          inst_valid = 1'b1;
          // Compare writes alongside any control-flow instruction are dropped.
          if (flag_we && !is_cf) begin
            f_eq_d = EQUAL;
            f_gt_d = GT;
          end
          if (is_halt) begin
            state_d = HALTED;
          end else if (take) begin
            branch_taken = 1'b1;
            pc_d         = target;
          end else if (pc_q == '1) begin
            pc_overflow_d = 1'b1;
            state_d       = HALTED;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      state_q       <= BOOT;
      pc_q          <= '0;
      f_eq_q        <= 1'b0;
      f_gt_q        <= 1'b0;
      pc_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      f_eq_q        <= f_eq_d;
      f_gt_q        <= f_gt_d;
      pc_overflow_q <= pc_overflow_d;
    end
  end

  assign PC          = pc_q;
  assign halt        = (state_q == HALTED);
  assign pc_overflow = pc_overflow_q;

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;

  always_comb begin
    instr_count_d = instr_count_q;
    taken_count_d = taken_count_q;
    if (inst_valid && (instr_count_q != '1)) begin
      instr_count_d = instr_count_q + CNT_W'(1);
    end
    if (branch_taken && (taken_count_q != '1)) begin
      taken_count_d = taken_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      instr_count_q <= '0;
      taken_count_q <= '0;
    end else begin
      instr_count_q <= instr_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign instr_count = instr_count_q;
  assign taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a behavioural InstROM.
// Perf-counter checks are compiled in only when FETCH_PERF_EN is defined.
module tb_fetch_sequencer;

  logic       CLK;
  logic       start;
  logic       stall;
  logic       flag_we;
  logic       EQUAL;
  logic       GT;
  logic [8:0] Instruction;
  logic [9:0] PC;
  logic       inst_valid;
  logic       branch_taken;
  logic       halt;
  logic       pc_overflow;
`ifdef FETCH_PERF_EN
  logic [15:0] instr_count;
  logic [15:0] taken_count;
`endif

  logic [8:0] rom [0:1023];
  int n_cmp;
  int n_err;

  assign Instruction = rom[PC];

  fetch_sequencer dut (
    .CLK          (CLK),
    .start        (start),
    .stall        (stall),
    .flag_we      (flag_we),
    .EQUAL        (EQUAL),
    .GT           (GT),
    .Instruction  (Instruction),
    .PC           (PC),
    .inst_valid   (inst_valid),
    .branch_taken (branch_taken),
    .halt         (halt),
    .pc_overflow  (pc_overflow)
`ifdef FETCH_PERF_EN
    ,
    .instr_count  (instr_count),
    .taken_count  (taken_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 9'd0;
  endtask

  // Leaves the DUT in BOOT, mid-cycle.
  task automatic do_reset();
    start = 1'b1; stall = 1'b0; flag_we = 1'b0; EQUAL = 1'b0; GT = 1'b0;
    tick();
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    start = 1'b1; stall = 1'b0; flag_we = 1'b0; EQUAL = 1'b0; GT = 1'b0;
    tick();
    n_cmp++; if (PC !== 10'd0) begin n_err++; $display("FAIL reset_pc got %0d want 0", PC); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    n_cmp++; if (halt !== 1'b0) begin n_err++; $display("FAIL reset_halt got %b want 0", halt); end
    n_cmp++; if (pc_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", pc_overflow); end
    n_cmp++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL reset_bt got %b want 0", branch_taken); end
    start = 1'b0;
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL boot_valid got %b want 0", inst_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (PC !== 10'(i)) begin n_err++; $display("FAIL seq_pc got %0d want %0d", PC, i); end
      n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid got %b want 1", inst_valid); end
      n_cmp++; if (halt !== 1'b0) begin n_err++; $display("FAIL seq_halt got %b want 0", halt); end
    end
  endtask

  task automatic test_halt();
    clear_rom();
    rom[5] = 9'b111_000_000;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (PC !== 10'd5) begin n_err++; $display("FAIL halt_at_pc got %0d want 5", PC); end
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL halt_valid got %b want 1", inst_valid); end
    n_cmp++; if (halt !== 1'b0) begin n_err++; $display("FAIL halt_early got %b want 0", halt); end
    tick();
    n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL halt_set got %b want 1", halt); end
    EQUAL = 1'b1; GT = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stall = i[0]; flag_we = i[1];
      tick();
      n_cmp++; if (PC !== 10'd5) begin n_err++; $display("FAIL halt_pc_hold got %0d want 5", PC); end
      n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL halt_sticky got %b want 1", halt); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL halt_valid_off got %b want 0", inst_valid); end
    end
    stall = 1'b0; flag_we = 1'b0;
  endtask

  task automatic test_beq(input logic eq, input logic [9:0] exp_pc);
    clear_rom();
    rom[3] = 9'b111_001_011;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    flag_we = 1'b1; EQUAL = eq;
    tick();
    flag_we = 1'b0; EQUAL = ~eq;
    #1;
    n_cmp++; if (PC !== 10'd3) begin n_err++; $display("FAIL beq_at_pc got %0d want 3", PC); end
    n_cmp++; if (branch_taken !== eq) begin n_err++; $display("FAIL beq_taken got %b want %b", branch_taken, eq); end
    tick();
    n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL beq_next_pc got %0d want %0d", PC, exp_pc); end
    n_cmp++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL beq_pulse got %b want 0", branch_taken); end
  endtask

  task automatic test_stall();
    clear_rom();
    rom[7] = 9'b111_011_101;
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    flag_we = 1'b1; GT = 1'b1;
    tick();
    // Compare write during stall must not clobber fGT.
    stall = 1'b1; GT = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (PC !== 10'd7) begin n_err++; $display("FAIL stall_pc got %0d want 7", PC); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL stall_valid got %b want 0", inst_valid); end
      n_cmp++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL stall_bt got %b want 0", branch_taken); end
      tick();
    end
    stall = 1'b0; flag_we = 1'b0;
    #1;
    n_cmp++; if (PC !== 10'd7) begin n_err++; $display("FAIL stall_resume_pc got %0d want 7", PC); end
    n_cmp++; if (branch_taken !== 1'b1) begin n_err++; $display("FAIL stall_resume_bt got %b want 1", branch_taken); end
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL stall_resume_valid got %b want 1", inst_valid); end
    tick();
    n_cmp++; if (PC !== 10'd100) begin n_err++; $display("FAIL stall_target got %0d want 100", PC); end
  endtask

  task automatic test_overflow();
    clear_rom();
    rom[0] = 9'b111_101_111;
    do_reset();
    tick();
    n_cmp++; if (branch_taken !== 1'b1) begin n_err++; $display("FAIL jmp_top_bt got %b want 1", branch_taken); end
    tick();
    n_cmp++; if (PC !== 10'd1023) begin n_err++; $display("FAIL top_pc got %0d want 1023", PC); end
    n_cmp++; if (pc_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", pc_overflow); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (pc_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", pc_overflow); end
      n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL ovf_halt got %b want 1", halt); end
      n_cmp++; if (PC !== 10'd1023) begin n_err++; $display("FAIL ovf_pc got %0d want 1023", PC); end
    end
  endtask

  task automatic test_top_branch();
    clear_rom();
    rom[0]    = 9'b111_101_111;
    rom[1023] = 9'b111_101_010;
    do_reset();
    tick();
    tick();
    n_cmp++; if (branch_taken !== 1'b1) begin n_err++; $display("FAIL top_branch_bt got %b want 1", branch_taken); end
    tick();
    n_cmp++; if (PC !== 10'd32) begin n_err++; $display("FAIL top_branch_pc got %0d want 32", PC); end
    n_cmp++; if (pc_overflow !== 1'b0) begin n_err++; $display("FAIL top_branch_ovf got %b want 0", pc_overflow); end
    n_cmp++; if (halt !== 1'b0) begin n_err++; $display("FAIL top_branch_halt got %b want 0", halt); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int cyc;
    clear_rom();
    rom[2]  = 9'b111_101_000;
    rom[18] = 9'b111_101_001;
    rom[28] = 9'b111_000_000;
    do_reset();
    cyc = 0;
    tick();
    while (!halt && cyc < 60) begin
      tick();
      cyc++;
    end
    n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL perf_halt_timeout got %b want 1", halt); end
    n_cmp++; if (PC !== 10'd28) begin n_err++; $display("FAIL perf_pc got %0d want 28", PC); end
    n_cmp++; if (instr_count !== 16'd11) begin n_err++; $display("FAIL perf_instr got %0d want 11", instr_count); end
    n_cmp++; if (taken_count !== 16'd2) begin n_err++; $display("FAIL perf_taken got %0d want 2", taken_count); end
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    #2;
    start = 1'b1;
    #1;
    n_cmp++; if (instr_count !== 16'd0) begin n_err++; $display("FAIL perf_async_instr got %0d want 0", instr_count); end
    n_cmp++; if (taken_count !== 16'd0) begin n_err++; $display("FAIL perf_async_taken got %0d want 0", taken_count); end
    n_cmp++; if (PC !== 10'd0) begin n_err++; $display("FAIL perf_async_pc got %0d want 0", PC); end
    start = 1'b0;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_halt();
    test_beq(1'b1, 10'd40);
    test_beq(1'b0, 10'd4);
    test_stall();
    test_overflow();
    test_top_branch();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
